mxrv_csr_file: RTL and testbench
================================

MXRV_CSR_FILE -- requirements
Module: mxrv_csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, CSR data width; legal values 32 or 64.
REQ-002 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-003 SHALL have parameter MTVEC_RST, default 0, reset value of mtvec.
REQ-004 SHALL have parameter MISA_VAL, default 32'h40000100 (RV32I), value returned by misa.
REQ-005 SHALL have a single clock; reset is asynchronous and active-low. Ports:
  clk  input  1  clock, all state on rising edge
  rst_n  input  1  asynchronous active-low reset
  csr_addr_i  input  12  CSR address
  csr_op_i  input  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
  csr_wdata_i  input  XLEN  write operand
  csr_rdata_o  output  XLEN  combinational old value at csr_addr_i
  csr_illegal_o  output  1  combinational illegal-access flag
  retire_i  input  1  one instruction retired this cycle
  trap_i  input  1  trap entry request
  trap_pc_i  input  XLEN  PC of trapping instruction
  trap_cause_i  input  XLEN  cause code
  trap_tval_i  input  XLEN  trap value
  mret_i  input  1  mret executed
  mtip_i, msip_i, meip_i  input  1 each  timer/software/external pending
  irq_o  output  1  interrupt request to core
  mtvec_o, mepc_o  output  XLEN  current mtvec, mepc

Function
REQ-006 SHALL implement: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14.
REQ-007 SHALL hold mcycle and minstret as 64-bit counters; mcycleh/minstreth read/write bits 63:32 only when XLEN=32, and are unimplemented when XLEN=64.
REQ-008 SHALL drive csr_rdata_o with the pre-write value when csr_op_i != 0; unimplemented addresses read 0.
REQ-009 SHALL compute new value: RW -> wdata; RS -> old|wdata; RC -> old&~wdata; commit at next rising edge.
REQ-010 SHALL suppress the write (no state change) for RS/RC with csr_wdata_i == 0.
REQ-011 SHALL assert csr_illegal_o when csr_op_i != 0 and (address unimplemented, or a write would occur to an address with addr[11:10]==2'b11); no state changes on illegal access.
REQ-012 SHALL implement mstatus MIE (bit 3) and MPIE (bit 7) writable; MPP (bits 12:11) read 2'b11; other bits read 0.
REQ-013 SHALL implement mie bits 3, 7, 11 writable; others read 0.
REQ-014 SHALL make mip read {meip_i at 11, mtip_i at 7, msip_i at 3}; writes to mip are ignored, not illegal.
REQ-015 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write.
REQ-016 SHALL implement mcountinhibit bit 0 (CY) and bit 2 (IR); others read 0.
REQ-017 SHALL increment mcycle every cycle when CY=0, minstret on retire_i when IR=0; both wrap from 2^64-1 to 0.
REQ-018 SHALL give a CSR write to a counter half precedence over that cycle's increment; the other half is unchanged.
REQ-019 SHALL, on trap_i: mepc<=trap_pc_i&~3, mcause<=trap_cause_i, mtval<=trap_tval_i, MPIE<=MIE, MIE<=0.
REQ-020 SHALL, on mret_i without trap_i: MIE<=MPIE, MPIE<=1.
REQ-021 SHALL give priority trap_i > mret_i > CSR write; lower-priority updates that cycle are discarded, counters still count.
REQ-022 SHALL drive irq_o = MIE & |(mie & mip), combinational.

Reset
REQ-023 SHALL on rst_n low clear mstatus, mie, mscratch, mepc, mcause, mtval, mcountinhibit, mcycle, minstret to 0 and load mtvec with MTVEC_RST immediately, without waiting for clk.
REQ-024 SHALL, during reset, produce irq_o=0 and csr_illegal_o follows inputs; counters start counting on the first edge after release.

Verification
REQ-025 After reset, CSRRW 0x340 wdata 0xDEADBEEF, then read 0x340 -> rdata 0xDEADBEEF; rdata during the write cycle 0.
REQ-026 Write mstatus 0x8; RS mie 0x80; raise mtip_i -> irq_o=1 same cycle; RC mstatus 0x8 -> irq_o=0 next cycle.
REQ-027 trap_i with pc 0x103, cause 0x80000007, MIE=1 -> mepc 0x100, mcause 0x80000007, MIE=0, MPIE=1; then mret_i -> MIE=1, MPIE=1.
REQ-028 RW to 0xF14 -> csr_illegal_o=1, mhartid unchanged; RS 0xF14 wdata 0 -> illegal 0, rdata HART_ID; RW 0x7C0 -> illegal 1.
REQ-029 Write mcycle=0xFFFFFFFF, mcycleh=0 (XLEN=32) -> next cycle mcycleh=1, mcycle=0; set CY -> mcycle frozen over 10 cycles.
REQ-030 Simultaneous trap_i and CSRRW mepc 0x500 -> mepc equals trap_pc_i&~3; assert rst_n mid-operation -> all REQ-023 values within same cycle.

Source files
------------

// File: rtl/mxrv_csr_file.sv
// Machine-mode CSR file: status/trap/counter registers for a single hart.
// Latency: reads and the illegal flag are combinational; writes and trap/mret updates commit on the next rising edge.
// Backpressure: none; every access completes in its cycle, and illegal or suppressed writes leave state untouched.
module mxrv_csr_file #(
    parameter int              XLEN      = 32,
    parameter int              HART_ID   = 0,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [31:0]     MISA_VAL  = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            retire_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            mtip_i,
    input  logic            msip_i,
    input  logic            meip_i,
    output logic            irq_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o
);

    localparam logic [11:0] A_MSTATUS       = 12'h300;
    localparam logic [11:0] A_MISA          = 12'h301;
    localparam logic [11:0] A_MIE           = 12'h304;
    localparam logic [11:0] A_MTVEC         = 12'h305;
    localparam logic [11:0] A_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] A_MSCRATCH      = 12'h340;
    localparam logic [11:0] A_MEPC          = 12'h341;
    localparam logic [11:0] A_MCAUSE        = 12'h342;
    localparam logic [11:0] A_MTVAL         = 12'h343;
    localparam logic [11:0] A_MIP           = 12'h344;
    localparam logic [11:0] A_MCYCLE        = 12'hB00;
    localparam logic [11:0] A_MINSTRET      = 12'hB02;
    localparam logic [11:0] A_MCYCLEH       = 12'hB80;
    localparam logic [11:0] A_MINSTRETH     = 12'hB82;
    localparam logic [11:0] A_MVENDORID     = 12'hF11;
    localparam logic [11:0] A_MARCHID       = 12'hF12;
    localparam logic [11:0] A_MIMPID        = 12'hF13;
    localparam logic [11:0] A_MHARTID       = 12'hF14;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};

    // Architectural state; only the implemented bits of mstatus/mie/mcountinhibit are stored
    logic            mst_mie_q;
    logic            mst_mpie_q;
    logic [2:0]      mie_q;          // {MEIE, MTIE, MSIE}
    logic            cy_inh_q;
    logic            ir_inh_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [63:0]     mcycle_q;
    logic [63:0]     minstret_q;
    logic [63:0]     mcycle_d;
    logic [63:0]     minstret_d;

    logic [2:0]      mip;            // {MEIP, MTIP, MSIP}
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wval;
    logic            impl;
    logic            wr_req;
    logic            illegal;
    logic            wr_en;

    assign mip = {meip_i, mtip_i, msip_i};

    always_comb begin
        rdata = '0;
        impl  = 1'b1;
        case (csr_addr_i)
            A_MSTATUS:       rdata = XLEN'({2'b11, 3'b000, mst_mpie_q, 3'b000, mst_mie_q, 3'b000});
            A_MISA:          rdata = XLEN'(MISA_VAL);
            A_MIE:           rdata = XLEN'({mie_q[2], 3'b000, mie_q[1], 3'b000, mie_q[0], 3'b000});
            A_MTVEC:         rdata = mtvec_q;
            A_MCOUNTINHIBIT: rdata = XLEN'({ir_inh_q, 1'b0, cy_inh_q});
            A_MSCRATCH:      rdata = mscratch_q;
            A_MEPC:          rdata = mepc_q;
            A_MCAUSE:        rdata = mcause_q;
            A_MTVAL:         rdata = mtval_q;
            A_MIP:           rdata = XLEN'({mip[2], 3'b000, mip[1], 3'b000, mip[0], 3'b000});
            A_MCYCLE:        rdata = mcycle_q[XLEN-1:0];
            A_MINSTRET:      rdata = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) rdata = XLEN'(mcycle_q[63:32]);
                else            impl  = 1'b0;
            end
            A_MINSTRETH: begin
                if (XLEN == 32) rdata = XLEN'(minstret_q[63:32]);
                else            impl  = 1'b0;
            end
            A_MVENDORID,
            A_MARCHID,
            A_MIMPID:        rdata = '0;
            A_MHARTID:       rdata = XLEN'(HART_ID);
            default:         impl  = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_i)
            OP_RW:   wval = csr_wdata_i;
            OP_RS:   wval = rdata | csr_wdata_i;
            OP_RC:   wval = rdata & ~csr_wdata_i;
            default: wval = rdata;
        endcase
    end

    // Set/clear with a zero mask is a pure read, so it is legal even on read-only CSRs
    assign wr_req  = (csr_op_i == OP_RW) || ((csr_op_i != OP_NONE) && (csr_wdata_i != '0));
    assign illegal = (csr_op_i != OP_NONE) && (!impl || (wr_req && (csr_addr_i[11:10] == 2'b11)));
    assign wr_en   = wr_req && !illegal && !trap_i && !mret_i;

    function automatic logic [63:0] cnt_lo(input logic [63:0] old, input logic [XLEN-1:0] wv);
        if (XLEN == 32) return {old[63:32], wv[31:0]};
        else            return 64'(wv);
    endfunction

    function automatic logic [63:0] cnt_hi(input logic [63:0] old, input logic [XLEN-1:0] wv);
        return {wv[31:0], old[31:0]};
    endfunction

    // A software write to one half replaces that cycle's increment; the other half holds
    always_comb begin
        mcycle_d   = cy_inh_q ? mcycle_q : mcycle_q + 64'd1;
        minstret_d = (retire_i && !ir_inh_q) ? minstret_q + 64'd1 : minstret_q;
        if (wr_en) begin
            case (csr_addr_i)
                A_MCYCLE:    mcycle_d   = cnt_lo(mcycle_q, wval);
                A_MINSTRET:  minstret_d = cnt_lo(minstret_q, wval);
                A_MCYCLEH:   if (XLEN == 32) mcycle_d   = cnt_hi(mcycle_q, wval);
                A_MINSTRETH: if (XLEN == 32) minstret_d = cnt_hi(minstret_q, wval);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            if (trap_i) begin
                mepc_q     <= trap_pc_i & ALIGN4;
                mcause_q   <= trap_cause_i;
                mtval_q    <= trap_tval_i;
                mst_mpie_q <= mst_mie_q;
                mst_mie_q  <= 1'b0;
            end else if (mret_i) begin
                mst_mie_q  <= mst_mpie_q;
                mst_mpie_q <= 1'b1;
            end else if (wr_en) begin
                case (csr_addr_i)
                    A_MSTATUS: begin
                        mst_mie_q  <= wval[3];
                        mst_mpie_q <= wval[7];
                    end
                    A_MIE:           mie_q      <= {wval[11], wval[7], wval[3]};
                    A_MTVEC:         mtvec_q    <= wval & ALIGN4;
                    A_MCOUNTINHIBIT: begin
                        cy_inh_q <= wval[0];
                        ir_inh_q <= wval[2];
                    end
                    A_MSCRATCH:      mscratch_q <= wval;
                    A_MEPC:          mepc_q     <= wval & ALIGN4;
                    A_MCAUSE:        mcause_q   <= wval;
                    A_MTVAL:         mtval_q    <= wval;
                    default: ;
                endcase
            end
        end
    end

    assign csr_rdata_o   = rdata;
    assign csr_illegal_o = illegal;
    assign irq_o         = mst_mie_q & (|(mie_q & mip));
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

endmodule

// File: tb/tb_mxrv_csr_file.sv
// Bench for mxrv_csr_file (XLEN=32): directed vectors with literal checks plus a per-cycle
// comparison against a register-map model keyed by CSR address.
module tb_mxrv_csr_file;

    localparam int          XLEN      = 32;
    localparam int          HART_ID   = 5;
    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
    localparam logic [31:0] MISA_VAL  = 32'h4000_0100;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        retire;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        mret;
    logic        mtip;
    logic        msip;
    logic        meip;
    logic        irq;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    mxrv_csr_file #(
        .XLEN(XLEN), .HART_ID(HART_ID), .MTVEC_RST(MTVEC_RST), .MISA_VAL(MISA_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_addr_i(csr_addr), .csr_op_i(csr_op), .csr_wdata_i(csr_wdata),
        .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
        .retire_i(retire), .trap_i(trap), .trap_pc_i(trap_pc),
        .trap_cause_i(trap_cause), .trap_tval_i(trap_tval), .mret_i(mret),
        .mtip_i(mtip), .msip_i(msip), .meip_i(meip),
        .irq_o(irq), .mtvec_o(mtvec), .mepc_o(mepc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: address-keyed storage plus 64-bit counters ----------------
    logic [31:0] st [logic [11:0]];
    logic [63:0] m_cyc;
    logic [63:0] m_inst;

    task automatic m_reset();
        st[12'h300] = 0; st[12'h304] = 0; st[12'h305] = MTVEC_RST; st[12'h320] = 0;
        st[12'h340] = 0; st[12'h341] = 0; st[12'h342] = 0; st[12'h343] = 0;
        m_cyc  = 0;
        m_inst = 0;
    endtask

    function automatic logic m_impl(input logic [11:0] a);
        return st.exists(a) || (a inside {12'h301, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                          12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14});
    endfunction

    function automatic logic [31:0] m_wmask(input logic [11:0] a);
        case (a)
            12'h300:          return 32'h0000_0088;
            12'h304:          return 32'h0000_0888;
            12'h305, 12'h341: return 32'hFFFF_FFFC;
            12'h320:          return 32'h0000_0005;
            default:          return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] m_mip();
        return (meip ? 32'h800 : 32'h0) | (mtip ? 32'h80 : 32'h0) | (msip ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return st[12'h300] | 32'h1800;
            12'h301: return MISA_VAL;
            12'h344: return m_mip();
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_inst[31:0];
            12'hB82: return m_inst[63:32];
            12'hF14: return HART_ID;
            default: return st.exists(a) ? st[a] : 32'h0;
        endcase
    endfunction

    function automatic logic m_wr_req(input logic [1:0] op, input logic [31:0] wd);
        return (op == 2'd1) || (op != 2'd0 && wd != 0);
    endfunction

    function automatic logic m_illegal(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        return (op != 2'd0) && (!m_impl(a) || (m_wr_req(op, wd) && a >= 12'hC00));
    endfunction

    function automatic logic m_irq();
        return st[12'h300][3] && ((st[12'h304] & m_mip()) != 0);
    endfunction

    task automatic m_step();
        logic [31:0] old;
        logic [31:0] nv;
        logic [63:0] ncyc;
        logic [63:0] ninst;
        logic        wr;
        old = m_read(csr_addr);
        wr  = m_wr_req(csr_op, csr_wdata) && !m_illegal(csr_op, csr_addr, csr_wdata);
        case (csr_op)
            2'd1:    nv = csr_wdata;
            2'd2:    nv = old | csr_wdata;
            default: nv = old & ~csr_wdata;
        endcase
        ncyc  = st[12'h320][0] ? m_cyc : m_cyc + 1;
        ninst = (retire && !st[12'h320][2]) ? m_inst + 1 : m_inst;
        if (trap) begin
            st[12'h341] = trap_pc & 32'hFFFF_FFFC;
            st[12'h342] = trap_cause;
            st[12'h343] = trap_tval;
            st[12'h300] = st[12'h300][3] ? 32'h80 : 32'h0;
        end else if (mret) begin
            st[12'h300] = 32'h80 | (st[12'h300][7] ? 32'h8 : 32'h0);
        end else if (wr) begin
            if (csr_addr == 12'hB00)      ncyc  = {m_cyc[63:32], nv};
            else if (csr_addr == 12'hB80) ncyc  = {nv, m_cyc[31:0]};
            else if (csr_addr == 12'hB02) ninst = {m_inst[63:32], nv};
            else if (csr_addr == 12'hB82) ninst = {nv, m_inst[31:0]};
            else if (st.exists(csr_addr)) st[csr_addr] = nv & m_wmask(csr_addr);
        end
        m_cyc  = ncyc;
        m_inst = ninst;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rdata", csr_rdata, m_read(csr_addr));
            chk("illegal", csr_illegal, m_illegal(csr_op, csr_addr, csr_wdata));
            chk("irq", irq, m_irq());
            chk("mtvec_o", mtvec, st[12'h305]);
            chk("mepc_o", mepc, st[12'h341]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = wd;
    endtask

    task automatic look(input logic [11:0] a);
        put(2'd0, a, 32'h0);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        put(2'd0, 12'h0, 32'h0);
        retire = 0; trap = 0; mret = 0; mtip = 0; msip = 0; meip = 0;
        trap_pc = 0; trap_cause = 0; trap_tval = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;

        look(12'h300);
        chk("rst_mstatus", csr_rdata, 32'h1800);
        chk("rst_mtvec", mtvec, 32'h1000);
        chk("rst_irq", irq, 1'b0);
        rst_n = 1'b1;
        tick(); look(12'hB00);
        chk("cyc_first_edge", csr_rdata, 32'h1);

        put(2'd1, 12'h340, 32'hDEAD_BEEF); #1;
        chk("rw_cycle_rdata", csr_rdata, 32'h0);
        tick(); look(12'h340);
        chk("mscratch_rd", csr_rdata, 32'hDEAD_BEEF);

        put(2'd1, 12'h300, 32'h8); tick();
        put(2'd2, 12'h304, 32'h80); tick();
        mtip = 1'b1; look(12'h344);
        chk("mip_mtip", csr_rdata, 32'h80);
        chk("irq_set", irq, 1'b1);
        put(2'd3, 12'h300, 32'h8); #1;
        chk("irq_hold", irq, 1'b1);
        tick(); look(12'h300);
        chk("irq_clr", irq, 1'b0);
        chk("mstatus_clr", csr_rdata, 32'h1800);
        mtip = 1'b0;
        put(2'd2, 12'h300, 32'h8); tick();

        trap = 1'b1; trap_pc = 32'h103; trap_cause = 32'h8000_0007; trap_tval = 32'hBAD;
        put(2'd0, 12'h0, 32'h0); tick();
        trap = 1'b0;
        look(12'h342);
        chk("trap_mcause", csr_rdata, 32'h8000_0007);
        chk("trap_mepc", mepc, 32'h100);
        look(12'h300);
        chk("trap_mstatus", csr_rdata, 32'h1880);
        look(12'h343);
        chk("trap_mtval", csr_rdata, 32'hBAD);
        mret = 1'b1; tick(); mret = 1'b0;
        look(12'h300);
        chk("mret_mstatus", csr_rdata, 32'h1888);

        put(2'd1, 12'hF14, 32'h77); #1;
        chk("hartid_rw_ill", csr_illegal, 1'b1);
        chk("hartid_rw_rd", csr_rdata, 32'd5);
        tick(); put(2'd2, 12'hF14, 32'h0); #1;
        chk("hartid_rs0_ill", csr_illegal, 1'b0);
        chk("hartid_rs0_rd", csr_rdata, 32'd5);
        put(2'd1, 12'h7C0, 32'h1); #1;
        chk("unimpl_ill", csr_illegal, 1'b1);
        chk("unimpl_rd", csr_rdata, 32'h0);
        tick(); put(2'd1, 12'h344, 32'hFFF); #1;
        chk("mip_wr_legal", csr_illegal, 1'b0);
        tick(); put(2'd1, 12'h305, 32'h1237);
        tick(); look(12'h305);
        chk("mtvec_align", mtvec, 32'h1234);

        put(2'd1, 12'hB00, 32'hFFFF_FFFF); tick();
        put(2'd1, 12'hB80, 32'h0); tick();
        look(12'hB80); chk("cych_written", csr_rdata, 32'h0);
        look(12'hB00); chk("cyc_held", csr_rdata, 32'hFFFF_FFFF);
        tick();
        look(12'hB80); chk("cych_carry", csr_rdata, 32'h1);
        look(12'hB00); chk("cyc_wrap", csr_rdata, 32'h0);
        put(2'd2, 12'h320, 32'h1); tick();
        look(12'hB00); chk("cyc_last_inc", csr_rdata, 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("cyc_frozen", csr_rdata, 32'h1);
        end
        put(2'd3, 12'h320, 32'h1); tick();

        look(12'hB02); chk("instret_idle", csr_rdata, 32'h0);
        retire = 1'b1; repeat (3) tick(); retire = 1'b0;
        look(12'hB02); chk("instret_3", csr_rdata, 32'h3);
        put(2'd2, 12'h320, 32'h4); retire = 1'b1; tick();
        put(2'd0, 12'hB02, 32'h0); tick(); retire = 1'b0;
        chk("instret_inh", csr_rdata, 32'h4);
        put(2'd3, 12'h320, 32'h4); tick();

        trap = 1'b1; trap_pc = 32'h2007; trap_cause = 32'h2; trap_tval = 32'h0;
        put(2'd1, 12'h341, 32'h500); tick();
        trap = 1'b0;
        look(12'h341);
        chk("trap_beats_wr", mepc, 32'h2004);

        put(2'd1, 12'h340, 32'h55);
        rst_n = 1'b0; #1;
        chk("arst_mtvec", mtvec, 32'h1000);
        chk("arst_mepc", mepc, 32'h0);
        chk("arst_mscratch", csr_rdata, 32'h0);
        chk("arst_irq", irq, 1'b0);
        put(2'd1, 12'hF14, 32'h1); #1;
        chk("arst_ill_follows", csr_illegal, 1'b1);
        tick(); rst_n = 1'b1;
        look(12'hB00); chk("arst_cyc", csr_rdata, 32'h0);
        tick(); look(12'hB00);
        chk("cyc_after_release", csr_rdata, 32'h1);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
